sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder_pkg.sv | 35 +++
 rtl/sram_like_responder_resp_delay_line.sv | 39 +++
 rtl/sram_like_responder.sv | 114 +++++++++++
 tb/tb_sram_like_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Purpose: shared types and constants for the SRAM-like responder slice.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: n/a. LFSR helpers serve the SRAM_LIKE_RESP_RANDOM_DELAY_EN build.
package sram_like_responder_pkg;

  // Transfer size encodings; informational only, carried for trace.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Legal parameter bounds.
  localparam int LATENCY_MIN     = 1;
  localparam int LATENCY_MAX     = 8;
  localparam int OUTSTANDING_MIN = 1;

  localparam int DATA_W = 32;

  // Seed loaded into the stall LFSR on every reset cycle.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // One delay-line stage: a response slot travelling toward data_ok.
  typedef struct packed {
    logic              vld;
    logic              is_read;
    logic [DATA_W-1:0] dat;
  } resp_t;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_delay_line.sv
// Purpose: fixed-length shift register of response slots {valid, is_read, data}.
// Latency: exactly STAGES cycles from in_dat to out_dat.
// Backpressure: none; advances every cycle, reset clears every slot.
module resp_delay_line
  import sram_like_responder_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  resp_t in_dat,
  output resp_t out_dat
);

  resp_t stage_q [STAGES];
  resp_t stage_d [STAGES];

  // Next state: new slot enters stage 0, every other slot moves one stage on.
  always_comb begin
    stage_d[0] = in_dat;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight response.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_dat = stage_q[STAGES-1];

endmodule

// File: rtl/sram_like_responder.sv
// Purpose: SRAM-like slave with 2^ADDR_W x 32-bit memory, byte-strobed writes, in-order responses.
// Latency: data_ok exactly LATENCY cycles after each accept; read data captured at accept.
// Backpressure: addr_ok low at OUTSTANDING in flight (or on LFSR stall with SRAM_LIKE_RESP_RANDOM_DELAY_EN); no response backpressure.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  // Outstanding never exceeds LATENCY, so LATENCY_MAX sizes the counter.
  localparam int CNT_W = $clog2(LATENCY_MAX + 1);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx;
  logic              stall;
  logic              accept;
  resp_t             push_dat;
  resp_t             pop_dat;

  // Size, high address bits and byte offset carry no function here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx = addr[ADDR_W+1:2];

`ifdef SRAM_LIKE_RESP_RANDOM_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running stall LFSR, reseeded on every reset cycle.
  always_comb begin
    lfsr_d = reset ? LFSR_SEED : lfsr_next(lfsr_q);
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Readiness never looks at req, so the requester may use it combinationally.
  assign addr_ok = !reset && (cnt_q < CNT_W'(OUTSTANDING)) && !stall;
  assign accept  = req && addr_ok;

  // Build the response slot; reads snapshot the word before any later write lands.
  always_comb begin
    push_dat         = '0;
    push_dat.vld     = accept;
    push_dat.is_read = accept && !wr;
    push_dat.dat     = (accept && !wr) ? mem_q[idx] : '0;
  end

  // Byte-strobed memory write in the accept cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Outstanding count: accept and completion in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop_dat.vld) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && pop_dat.vld) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outstanding count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  resp_delay_line #(
    .STAGES (LATENCY)
  ) u_resp_delay_line (
    .clk     (clk),
    .reset   (reset),
    .in_dat  (push_dat),
    .out_dat (pop_dat)
  );

  // Outputs are forced quiet during reset, before the delay line has cleared.
  assign data_ok = !reset && pop_dat.vld;
  assign rdata   = (!reset && pop_dat.vld && pop_dat.is_read) ? pop_dat.dat : '0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Purpose: self-checking bench for sram_like_responder (LATENCY=2 and LATENCY=3 instances, shared stimulus).
// Latency: reference model schedules each response LATENCY cycles after accept on a cycle timeline.
// Backpressure: model predicts addr_ok from its own outstanding count (and LFSR with SRAM_LIKE_RESP_RANDOM_DELAY_EN).
module tb_sram_like_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 3;
  localparam int OUTS = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        aok  [2];
  logic        dok  [2];
  logic [31:0] rdat [2];

  sram_like_responder dut0 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdat[0])
  );

  sram_like_responder #(.ADDR_W(10), .LATENCY(LAT1), .OUTSTANDING(OUTS)) dut1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: per-instance memory, outstanding count and a response timeline.
  int          mcnt [2];
  bit          sv   [2][16];
  logic [31:0] sd   [2][16];
  logic [31:0] mmem [2][1024];
  logic [7:0]  mlfsr = 8'hA5;
  logic [31:0] last_rd [2];
  logic        last_aok [2];
  int          dok_seen [2];
  int          b_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit exp_aok(input int k);
    bit stall;
    stall = 1'b0;
`ifdef SRAM_LIKE_RESP_RANDOM_DELAY_EN
    stall = mlfsr[0];
`endif
    return !reset && (mcnt[k] < OUTS) && !stall;
  endfunction

  // Compare DUT outputs for the current cycle against the model, then advance the model.
  task automatic step();
    bit          e_aok, e_dok, acc;
    logic [31:0] e_rd;
    logic [9:0]  idx;
    int          slot, due;
    slot = cyc % 16;
    idx  = addr[11:2];
    for (int k = 0; k < 2; k++) begin
      e_aok = exp_aok(k);
      e_dok = !reset && sv[k][slot];
      e_rd  = e_dok ? sd[k][slot] : 32'h0;
      chk($sformatf("addr_ok_l%0d", lat_of(k)), 32'(aok[k]), 32'(e_aok));
      chk($sformatf("data_ok_l%0d", lat_of(k)), 32'(dok[k]), 32'(e_dok));
      chk($sformatf("rdata_l%0d", lat_of(k)), rdat[k], e_rd);
      last_aok[k] = aok[k];
      if (dok[k]) begin
        dok_seen[k]++;
        last_rd[k] = rdat[k];
      end
      sv[k][slot] = 1'b0;
      if (reset) begin
        mcnt[k] = 0;
        for (int s = 0; s < 16; s++) sv[k][s] = 1'b0;
      end else begin
        acc = req && e_aok;
        if (acc) begin
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
          end
          due = (slot + lat_of(k)) % 16;
          sv[k][due] = 1'b1;
          sd[k][due] = wr ? 32'h0 : mmem[k][idx];
          if (k == 1) b_acc++;
        end
        mcnt[k] = mcnt[k] + (acc ? 1 : 0) - (e_dok ? 1 : 0);
      end
    end
    mlfsr = reset ? 8'hA5 : {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0;
    cycle();
  endtask

  // Present one transaction only when both instances will take it in the same cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int g;
    g = 0;
    while (!(exp_aok(0) && exp_aok(1)) && g < 50) begin
      idle();
      g++;
    end
    if (g >= 50) chk("issue_wait", g, 0);
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    cycle();
    req = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((mcnt[0] != 0 || mcnt[1] != 0) && g < 40) begin
      idle();
      g++;
    end
    if (g >= 40) chk("drain_timeout", mcnt[0] + mcnt[1], 0);
    idle();
  endtask

  task automatic rand_inputs();
    logic [31:0] a;
    a = $urandom;
    a[11:6] = 6'd0;
    addr  = a;
    wr    = 1'($urandom_range(0, 1));
    wstrb = 4'($urandom_range(0, 15));
    wdata = $urandom;
    size  = 2'($urandom_range(0, 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int p0;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      dok_seen[k] = 0;
      last_rd[k] = 32'h0;
      last_aok[k] = 1'b0;
    end
    repeat (3) cycle();
    reset = 1'b0;

    // Preload the word region used by every test.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);
    drain();

    // Full write then read back.
    issue(1'b1, 32'h1C000010, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h1C000010, 32'h0, 4'h0);
    drain();
    chk("wr_rd_l2", last_rd[0], 32'hDEADBEEF);
    chk("wr_rd_l3", last_rd[1], 32'hDEADBEEF);

    // Partial-strobe merge.
    issue(1'b1, 32'h00000020, 32'h11223344, 4'hF);
    issue(1'b1, 32'h00000020, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h00000020, 32'h0, 4'h0);
    drain();
    chk("strobe_l2", last_rd[0], 32'h11BB33DD);
    chk("strobe_l3", last_rd[1], 32'h11BB33DD);

    // Address wrap past 2^ADDR_W words.
    issue(1'b1, 32'h00001000, 32'h5A5A5A5A, 4'hF);
    issue(1'b0, 32'h00000000, 32'h0, 4'h0);
    drain();
    chk("wrap_l2", last_rd[0], 32'h5A5A5A5A);
    chk("wrap_l3", last_rd[1], 32'h5A5A5A5A);

    // Hold req high until the LATENCY=3 instance has accepted 6 reads.
    b_acc = 0;
    p0 = dok_seen[1];
    for (int g = 0; g < 100 && b_acc < 6; g++) begin
      req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = 32'((g % 16) * 4);
      cycle();
    end
    req = 1'b0;
    drain();
    chk("hold_accepts", b_acc, 6);
    chk("hold_pulses", dok_seen[1] - p0, 6);

    // Reset with reads in flight drops their responses.
    issue(1'b0, 32'h00000004, 32'h0, 4'h0);
    issue(1'b0, 32'h00000008, 32'h0, 4'h0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    p0 = dok_seen[0] + dok_seen[1];
    idle();
`ifndef SRAM_LIKE_RESP_RANDOM_DELAY_EN
    chk("aok_after_rst_l2", 32'(last_aok[0]), 32'd1);
    chk("aok_after_rst_l3", 32'(last_aok[1]), 32'd1);
`endif
    repeat (9) idle();
    chk("rst_no_dok", dok_seen[0] + dok_seen[1] - p0, 0);

    // Random traffic, then req held high continuously.
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      req = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      req = 1'b1;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
